// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_arb_pkg
// Brief    : Shared state encoding and abort data for the VRAM arbiter.
// Revision : 1.0
// ============================================================================
package vram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID1 = 2'd1,
        ST_VID2 = 2'd2,
        ST_CPU  = 2'd3
    } arb_state_t;

    localparam logic [15:0] c_ABORT_DATA = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares one VRAM port between two-word video fetches and byte CPU
//            accesses, with per-access timeout and sticky error flags.
// Revision : 1.0
// ============================================================================
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr1,
    input  logic [ADDR_W-1:0] vid_addr2,
    output logic [15:0]       vid_data1,
    output logic [15:0]       vid_data2,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              vid_overrun,
    output logic              mem_timeout
);

    localparam int                  c_WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                w_grant_vid;
    logic                w_grant_cpu;
    logic                w_cap_vid1;
    logic                w_cap_vid2;
    logic                w_cap_cpu;
    logic                w_vid2_issue;

    logic                r_vid_pend;
    logic                r_cpu_turn;
    logic [ADDR_W-1:0]   r_vid_addr1;
    logic [ADDR_W-1:0]   r_vid_addr2;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_cpu_lsb;
    logic [c_WAIT_W-1:0] r_wait;
    logic [15:0]         r_vid_data1;
    logic [15:0]         r_vid_data2;
    logic                r_vid_valid;
    logic [7:0]          r_cpu_rdata;
    logic                r_cpu_ack;
    logic                r_vid_overrun;
    logic                r_mem_timeout;

    logic                w_vid_busy;
    logic                w_vid_accept;
    logic                w_vid_drop;
    logic                w_cpu_ok;
    logic                w_abort;
    logic                w_done;
    logic [15:0]         w_rdata;

    assign w_vid_busy   = r_vid_pend || (r_state == ST_VID1) || (r_state == ST_VID2);
    assign w_vid_accept = vid_req && !w_vid_busy;
    assign w_vid_drop   = vid_req && w_vid_busy;
    // cpu_req may still be high in the cpu_ack cycle; never re-grant it there
    assign w_cpu_ok     = cpu_req && !r_cpu_ack;

    // mem_ack only counts while a request is outstanding
    assign w_abort = r_mem_req && !mem_ack && (r_wait == c_WAIT_LAST);
    assign w_done  = r_mem_req && (mem_ack || w_abort);
    assign w_rdata = mem_ack ? mem_rdata : c_ABORT_DATA;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_cpu_turn gives a waiting CPU the slot right after a video pair
    always_comb begin
        w_state_next = r_state;
        w_grant_vid  = 1'b0;
        w_grant_cpu  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cpu_turn && w_cpu_ok) begin
                    w_grant_cpu  = 1'b1;
                    w_state_next = ST_CPU;
                end else if (r_vid_pend || vid_req) begin
                    w_grant_vid  = 1'b1;
                    w_state_next = ST_VID1;
                end else if (w_cpu_ok) begin
                    w_grant_cpu  = 1'b1;
                    w_state_next = ST_CPU;
                end
            end
            ST_VID1: if (w_done) w_state_next = ST_VID2;
            ST_VID2: if (w_done) w_state_next = ST_IDLE;
            ST_CPU:  if (w_done) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cap_vid1   = 1'b0;
        w_cap_vid2   = 1'b0;
        w_cap_cpu    = 1'b0;
        w_vid2_issue = 1'b0;
        case (r_state)
            ST_VID1: w_cap_vid1 = w_done;
            ST_VID2: begin
                w_cap_vid2   = w_done;
                w_vid2_issue = !r_mem_req;
            end
            ST_CPU:  w_cap_cpu = w_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vid_pend    <= 1'b0;
            r_cpu_turn    <= 1'b0;
            r_vid_addr1   <= '0;
            r_vid_addr2   <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cpu_lsb     <= 1'b0;
            r_wait        <= '0;
            r_vid_data1   <= '0;
            r_vid_data2   <= '0;
            r_vid_valid   <= 1'b0;
            r_cpu_rdata   <= '0;
            r_cpu_ack     <= 1'b0;
            r_vid_overrun <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_vid_accept) begin
                r_vid_addr1 <= vid_addr1;
                r_vid_addr2 <= vid_addr2;
            end
            if (w_grant_vid) begin
                r_vid_pend <= 1'b0;
            end else if (w_vid_accept) begin
                r_vid_pend <= 1'b1;
            end
            if (w_vid_drop) begin
                r_vid_overrun <= 1'b1;
            end

            if (w_cap_vid2) begin
                r_cpu_turn <= 1'b1;
            end else if (w_grant_vid || w_grant_cpu) begin
                r_cpu_turn <= 1'b0;
            end

            // The second video word goes out after a one-cycle mem_req gap
            if (w_grant_vid) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_vid_accept ? vid_addr1 : r_vid_addr1;
            end else if (w_grant_cpu) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= cpu_we;
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
                r_cpu_lsb   <= cpu_addr[0];
            end else if (w_cap_vid1) begin
                r_mem_req  <= 1'b0;
                r_mem_addr <= r_vid_addr2;
            end else if (w_vid2_issue) begin
                r_mem_req <= 1'b1;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end

            if (!r_mem_req || w_done) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_abort) begin
                r_mem_timeout <= 1'b1;
            end

            if (w_cap_vid1) begin
                r_vid_data1 <= w_rdata;
            end
            if (w_cap_vid2) begin
                r_vid_data2 <= w_rdata;
            end
            if (w_cap_cpu && !r_mem_we) begin
                r_cpu_rdata <= r_cpu_lsb ? w_rdata[15:8] : w_rdata[7:0];
            end
            r_vid_valid <= w_cap_vid2;
            r_cpu_ack   <= w_cap_cpu;
        end
    end

    assign vid_data1   = r_vid_data1;
    assign vid_data2   = r_vid_data2;
    assign vid_valid   = r_vid_valid;
    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_ack     = r_cpu_ack;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign vid_overrun = r_vid_overrun;
    assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter with a delayed-ack memory model.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;

    localparam int c_ADDR_W = 19;

    logic                clk_sys = 1'b0;
    logic                reset;
    logic                vid_req;
    logic [c_ADDR_W-1:0] vid_addr1;
    logic [c_ADDR_W-1:0] vid_addr2;
    logic [15:0]         vid_data1;
    logic [15:0]         vid_data2;
    logic                vid_valid;
    logic                cpu_req;
    logic                cpu_we;
    logic [c_ADDR_W-1:0] cpu_addr;
    logic [7:0]          cpu_wdata;
    logic [7:0]          cpu_rdata;
    logic                cpu_ack;
    logic                mem_req;
    logic                mem_we;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [7:0]          mem_wdata;
    logic [15:0]         mem_rdata;
    logic                mem_ack;
    logic                vid_overrun;
    logic                mem_timeout;

    vram_arbiter #(.ADDR_W(c_ADDR_W), .MEM_TIMEOUT(15)) u_dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr1   (vid_addr1),
        .vid_addr2   (vid_addr2),
        .vid_data1   (vid_data1),
        .vid_data2   (vid_data2),
        .vid_valid   (vid_valid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .vid_overrun (vid_overrun),
        .mem_timeout (mem_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  inject_cycle = -1;
    int  ack_delay = 2;
    bit  ack_en    = 1'b1;

    logic [31:0]         exp_vid_q[$];
    logic [7:0]          exp_cpu_q[$];
    logic [c_ADDR_W-1:0] ack_addr_q[$];
    logic [7:0]          last_cpu_rdata = 8'h00;
    int  n_vid = 0;
    int  n_cpu = 0;
    int  n_rise = 0;
    int  n_req_hi = 0;
    logic prev_req = 1'b0;
    logic last_we = 1'b0;
    logic [7:0] last_wdata = 8'h00;

    function automatic logic [15:0] mem_model(input logic [c_ADDR_W-1:0] a);
        case (a)
            19'h00100: return 16'h1234;
            19'h00102: return 16'h5678;
            19'h00101: return 16'hAB12;
            default:   return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // Memory: acks ack_delay cycles into a request, or once on inject_cycle
    initial begin : p_mem
        int cnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (cyc == inject_cycle) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h1111;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req === 1'b1 && ack_en) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk_sys);
        if (mem_req && !prev_req) n_rise++;
        prev_req = mem_req;
        if (mem_req) begin
            n_req_hi++;
            last_we    = mem_we;
            last_wdata = mem_wdata;
        end
        if (mem_req && mem_ack) ack_addr_q.push_back(mem_addr);
        if (vid_valid) begin
            n_vid++;
            if (exp_vid_q.size() == 0) begin
                check("vid_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_vid_q.pop_front();
                check("vid_data1", {16'h0, vid_data1}, {16'h0, e[31:16]});
                check("vid_data2", {16'h0, vid_data2}, {16'h0, e[15:0]});
            end
        end
        if (cpu_ack) begin
            n_cpu++;
            cpu_req = 1'b0;
            if (exp_cpu_q.size() == 0) begin
                check("cpu_ack_unexpected", 32'd1, 32'd0);
            end else begin
                check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, exp_cpu_q.pop_front()});
            end
        end
    endtask

    task automatic clear_logs();
        ack_addr_q.delete();
        n_vid = 0;
        n_cpu = 0;
        n_rise = 0;
        n_req_hi = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        last_cpu_rdata = 8'h00;
        tick();
        clear_logs();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_vid_q.size() != 0 || exp_cpu_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", {31'h0, (exp_vid_q.size() != 0 || exp_cpu_q.size() != 0)}, 32'd0);
        repeat (4) tick();
    endtask

    task automatic video(input logic [c_ADDR_W-1:0] a1, input logic [c_ADDR_W-1:0] a2, input bit expect_it);
        if (expect_it) exp_vid_q.push_back({mem_model(a1), mem_model(a2)});
        vid_addr1 = a1;
        vid_addr2 = a2;
        vid_req   = 1'b1;
        tick();
        vid_req = 1'b0;
    endtask

    task automatic cpu_start(input bit we, input logic [c_ADDR_W-1:0] a, input logic [7:0] wd);
        logic [15:0] d;
        if (!we) begin
            d = mem_model(a);
            last_cpu_rdata = a[0] ? d[15:8] : d[7:0];
        end
        exp_cpu_q.push_back(last_cpu_rdata);
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
    endtask

    initial begin : p_main
        reset = 1'b1; vid_req = 1'b0; vid_addr1 = '0; vid_addr2 = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        do_reset();

        check("rst_mem_req",     {31'h0, mem_req},     32'd0);
        check("rst_mem_we",      {31'h0, mem_we},      32'd0);
        check("rst_flags",       {30'h0, vid_overrun, mem_timeout}, 32'd0);
        check("rst_pulses",      {30'h0, vid_valid, cpu_ack}, 32'd0);
        check("rst_vid_data",    {vid_data1, vid_data2}, 32'd0);
        check("rst_cpu_rdata",   {24'h0, cpu_rdata},   32'd0);
        check("rst_mem_addr",    {13'h0, mem_addr},    32'd0);
        check("rst_mem_wdata",   {24'h0, mem_wdata},   32'd0);

        // Basic video pair
        ack_delay = 2;
        video(19'h00100, 19'h00102, 1'b1);
        drain(60);
        check("vid1_pulses", n_vid, 32'd1);
        check("vid1_hold", {vid_data1, vid_data2}, 32'h12345678);

        // CPU read of the odd byte
        clear_logs();
        cpu_start(1'b0, 19'h00101, 8'h00);
        drain(60);
        check("cpu_rd_pulses", n_cpu, 32'd1);
        check("cpu_rd_we", {31'h0, last_we}, 32'd0);

        // Same-cycle conflict: video pair first, then CPU, gaps between all
        clear_logs();
        cpu_start(1'b0, 19'h00300, 8'h00);
        video(19'h00200, 19'h00204, 1'b1);
        drain(100);
        check("conf_rises", n_rise, 32'd3);
        check("conf_n_acks", ack_addr_q.size(), 32'd3);
        if (ack_addr_q.size() == 3) begin
            check("conf_order0", {13'h0, ack_addr_q[0]}, 32'h200);
            check("conf_order1", {13'h0, ack_addr_q[1]}, 32'h204);
            check("conf_order2", {13'h0, ack_addr_q[2]}, 32'h300);
        end

        // Overrun during VID2
        clear_logs();
        ack_delay = 4;
        check("ovr_before", {31'h0, vid_overrun}, 32'd0);
        video(19'h00400, 19'h00402, 1'b1);
        begin
            int n = 0;
            while (n_rise < 2 && n < 40) begin tick(); n++; end
            check("ovr_reach_vid2", n_rise, 32'd2);
        end
        video(19'h00500, 19'h00502, 1'b0);
        drain(60);
        repeat (10) tick();
        check("ovr_flag", {31'h0, vid_overrun}, 32'd1);
        check("ovr_pulses", n_vid, 32'd1);
        check("ovr_rises", n_rise, 32'd2);
        if (ack_addr_q.size() == 2) check("ovr_addr2", {13'h0, ack_addr_q[1]}, 32'h402);
        else check("ovr_n_acks", ack_addr_q.size(), 32'd2);

        // CPU write that never gets acked
        clear_logs();
        ack_en = 1'b0;
        cpu_start(1'b1, 19'h00600, 8'h3C);
        drain(60);
        check("to_flag", {31'h0, mem_timeout}, 32'd1);
        check("to_req_cycles", n_req_hi, 32'd15);
        check("to_pulses", n_cpu, 32'd1);
        check("to_we_wdata", {23'h0, last_we, last_wdata}, 32'h13C);
        ack_en = 1'b1;
        ack_delay = 1;
        clear_logs();
        cpu_start(1'b0, 19'h00101, 8'h00);
        drain(60);
        check("to_back_idle", n_cpu, 32'd1);

        // Reset in VID1 with a stray ack one cycle later
        ack_en = 1'b0;
        clear_logs();
        video(19'h00100, 19'h00102, 1'b0);
        check("rst_mid_in_vid1", {31'h0, mem_req}, 32'd1);
        reset = 1'b1;
        inject_cycle = cyc + 1;
        tick();
        check("rst_mid_req_drop", {31'h0, mem_req}, 32'd0);
        reset = 1'b0;
        n_req_hi = 0;
        repeat (10) tick();
        check("rst_mid_req_hi", n_req_hi, 32'd0);
        check("rst_mid_vid", n_vid, 32'd0);
        check("rst_mid_flags", {29'h0, vid_overrun, mem_timeout, vid_valid}, 32'd0);
        check("rst_mid_data", {16'h0, vid_data1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
